// File: rtl/stream_unpacker_pkg.sv
// Shared video definitions for the pixel packer / stream_unpacker pair:
// default frame geometry, alignment state encoding and the RGB pixel type.
package stream_unpacker_pkg;

    localparam int X_SIZE_DEF = 640;
    localparam int Y_SIZE_DEF = 480;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } vid_state_e;

    // Blue occupies the low byte, matching the packed byte order on the wire.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

endpackage

// File: rtl/stream_unpacker_if.sv
// 32-bit AXI-Stream video link carrying packed 24-bit pixels with
// tuser marking the first word of a frame and tlast the last word of a line.
interface stream_unpacker_if;

    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tuser;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);

endinterface

// File: rtl/stream_unpacker_byte_fifo8.sv
// 8-byte shift buffer for stream_unpacker: appends a 32-bit word at the
// post-pop fill level and pops one 3-byte pixel from the bottom.
module byte_fifo8
    import stream_unpacker_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        pop,
    input  logic        push,
    input  logic        load,
    input  logic [31:0] word,
    output pixel_t      head,
    output logic [3:0]  cnt,
    output logic [3:0]  cnt_after_pop
);

    logic [63:0] data_q;
    logic [63:0] data_d;
    logic [63:0] shifted;
    logic [63:0] ins_mask;
    logic [63:0] ins_data;
    logic [3:0]  cnt_d;
    logic [6:0]  ofs;

    always_comb begin
        // NOTE: every variable gets a value before any branch, so no latch can be inferred.
        cnt_after_pop = pop ? cnt - 4'd3 : cnt;
        shifted       = pop ? {24'h0, data_q[63:24]} : data_q;
        ofs           = {cnt_after_pop, 3'b000};
        ins_mask      = {32'h0, 32'hFFFF_FFFF} << ofs;
        ins_data      = {32'h0, word} << ofs;
        data_d        = shifted;
        cnt_d         = cnt_after_pop;
        if (load) begin
            data_d = {32'h0, word};
            cnt_d  = 4'd4;
        end else if (push) begin
            data_d = (shifted & ~ins_mask) | ins_data;
            cnt_d  = cnt_after_pop + 4'd4;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cnt <= 4'd0;
        end else begin
            cnt <= cnt_d;
        end
    end

    // NOTE: byte storage is deliberately not reset; cnt alone says which bytes are meaningful.
    always_ff @(posedge aclk) begin
        data_q <= data_d;
    end

    assign head = pixel_t'(data_q[23:0]);

endmodule

// File: rtl/stream_unpacker.sv
// Unpacks 3 words into 4 RGB pixels, locks onto tuser and checks line/frame
// geometry. Define UNPACKER_ERR_CNT_EN to implement the sof/eol error counters.
module stream_unpacker
    import stream_unpacker_pkg::*;
#(
    parameter int X_SIZE = X_SIZE_DEF,
    parameter int Y_SIZE = Y_SIZE_DEF,
    parameter int CNT_W  = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    stream_unpacker_if.slave in_stream,
    output logic [7:0]       r,
    output logic [7:0]       g,
    output logic [7:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sof,
    output logic             out_eol,
    output logic             locked,
    output logic [CNT_W-1:0] sof_err_cnt,
    output logic [CNT_W-1:0] eol_err_cnt
);

    localparam int WPL  = 3 * X_SIZE / 4;
    localparam int WX_W = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int WY_W = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam int X_W  = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam logic [WX_W-1:0] WX_LAST = WX_W'(WPL - 1);
    localparam logic [WY_W-1:0] Y_LAST  = WY_W'(Y_SIZE - 1);
    localparam logic [X_W-1:0]  X_LAST  = X_W'(X_SIZE - 1);

    vid_state_e      state_q;
    vid_state_e      state_d;
    logic [WX_W-1:0] wx;
    logic [WY_W-1:0] wy;
    logic [X_W-1:0]  x;
    logic [WY_W-1:0] y;
    logic [3:0]      cnt;
    logic [3:0]      cnt_after_pop;
    pixel_t          head;
    logic            emit;
    logic            accept;
    logic            load;
    logic            push;
    logic            at_frame_start;
    logic            wx_wrap;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_HUNT && accept && in_stream.tuser) begin
            state_d = ST_LOCKED;
        end
    end

    always_comb begin
        locked    = (state_q == ST_LOCKED);
        out_valid = locked && (cnt >= 4'd3);
        r         = '0;
        g         = '0;
        b         = '0;
        out_sof   = 1'b0;
        out_eol   = 1'b0;
        if (out_valid) begin
            r       = head.r;
            g       = head.g;
            b       = head.b;
            out_sof = (x == '0) && (y == '0);
            out_eol = (x == X_LAST);
        end
    end

    // Room check uses the fill level after this cycle's pop, so emit and accept overlap.
    assign in_stream.tready = aresetn && (!locked || cnt_after_pop <= 4'd4);
    assign emit           = out_valid && out_ready;
    assign accept         = in_stream.tvalid && in_stream.tready;
    assign at_frame_start = (wx == '0) && (wy == '0);
    assign wx_wrap        = (wx == WX_LAST);
    assign load           = accept && in_stream.tuser && (!locked || !at_frame_start);
    assign push           = accept && locked && !load;

    byte_fifo8 u_fifo (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .pop           (emit),
        .push          (push),
        .load          (load),
        .word          (in_stream.tdata),
        .head          (head),
        .cnt           (cnt),
        .cnt_after_pop (cnt_after_pop)
    );

    // A frame-start word counts as input word 0, so the word counter restarts at 1.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wx <= '0;
            wy <= '0;
            x  <= '0;
            y  <= '0;
        end else if (load) begin
            wx <= WX_W'(1);
            wy <= '0;
            x  <= '0;
            y  <= '0;
        end else begin
            if (push) begin
                if (wx_wrap) begin
                    wx <= '0;
                    wy <= (wy == Y_LAST) ? '0 : wy + WY_W'(1);
                end else begin
                    wx <= wx + WX_W'(1);
                end
            end
            if (emit) begin
                if (x == X_LAST) begin
                    x <= '0;
                    y <= (y == Y_LAST) ? '0 : y + WY_W'(1);
                end else begin
                    x <= x + X_W'(1);
                end
            end
        end
    end

`ifdef UNPACKER_ERR_CNT_EN
    logic eol_mismatch;
    logic tkeep_unused;

    assign eol_mismatch = accept && locked && (in_stream.tlast != wx_wrap);
    assign tkeep_unused = ^in_stream.tkeep;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            sof_err_cnt <= '0;
            eol_err_cnt <= '0;
        end else begin
            if (load && locked && sof_err_cnt != '1) begin
                sof_err_cnt <= sof_err_cnt + CNT_W'(1);
            end
            if (eol_mismatch && eol_err_cnt != '1) begin
                eol_err_cnt <= eol_err_cnt + CNT_W'(1);
            end
        end
    end
`else
    logic tkeep_unused;

    assign tkeep_unused = ^{in_stream.tkeep, in_stream.tlast};
    assign sof_err_cnt  = '0;
    assign eol_err_cnt  = '0;
`endif

endmodule

// File: tb/tb_stream_unpacker.sv
// Randomized bench for stream_unpacker: frames are packed from random pixels and
// the output is scored against a word/pixel-level reference queue.
module tb_stream_unpacker;
    import stream_unpacker_pkg::*;

    localparam int XS  = 16;
    localparam int YS  = 4;
    localparam int CW  = 2;
    localparam int WPL = 3 * XS / 4;
    localparam int FW  = WPL * YS;
`ifdef UNPACKER_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        bit          user;
        bit          last;
        int          npx;
        logic [25:0] e0;
        logic [25:0] e1;
    } word_t;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [7:0]    r, g, b;
    logic          out_valid, out_ready, out_sof, out_eol, locked;
    logic [CW-1:0] sof_err_cnt, eol_err_cnt;

    stream_unpacker_if in_stream ();

    stream_unpacker #(.X_SIZE(XS), .Y_SIZE(YS), .CNT_W(CW)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .in_stream   (in_stream),
        .r           (r),
        .g           (g),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sof     (out_sof),
        .out_eol     (out_eol),
        .locked      (locked),
        .sof_err_cnt (sof_err_cnt),
        .eol_err_cnt (eol_err_cnt)
    );

    always #5 aclk = ~aclk;

    int          n_cmp = 0;
    int          n_bad = 0;
    word_t       txq[$];
    logic [25:0] exp_q[$];
    bit          m_locked;
    int          m_wx, m_wy;
    bit          stall_prev, sof_next, first_seen;
    logic [26:0] hold_val;
    logic [25:0] first_px;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [25:0] expv(input pixel_t p, input int x, input int y);
        return {p, (x == 0 && y == 0), (x == XS - 1)};
    endfunction

    // Packs one frame; only the first n_words words are queued. bad_last/drop_last
    // force or clear tlast on that frame-relative word index.
    task automatic add_frame(input int n_words, input int bad_last, input int drop_last,
                             input bit forced);
        pixel_t      p[4];
        word_t       w;
        logic [31:0] rnd;
        int          wi = 0;
        for (int ln = 0; ln < YS; ln++) begin
            for (int gi = 0; gi < XS / 4; gi++) begin
                for (int k = 0; k < 4; k++) begin
                    rnd  = $urandom();
                    p[k] = rnd[23:0];
                end
                if (forced && wi == 0) begin
                    p[0]      = 24'h332211;
                    p[1][7:0] = 8'h44;
                end
                for (int j = 0; j < 3; j++) begin
                    if (j == 0)      w.data = {p[1][7:0], p[0]};
                    else if (j == 1) w.data = {p[2][15:0], p[1][23:8]};
                    else             w.data = {p[3], p[2][23:16]};
                    w.user = (wi == 0);
                    w.last = (j == 2) && (gi == XS / 4 - 1);
                    if (wi == bad_last)  w.last = 1'b1;
                    if (wi == drop_last) w.last = 1'b0;
                    w.npx = (j == 2) ? 2 : 1;
                    w.e0  = expv(p[j], gi * 4 + j, ln);
                    w.e1  = expv(p[3], gi * 4 + 3, ln);
                    if (wi < n_words) txq.push_back(w);
                    wi++;
                end
            end
        end
    endtask

    task automatic model_accept(input word_t w);
        if (!m_locked) begin
            if (!w.user) return;
            m_locked = 1'b1;
            m_wx     = 0;
            m_wy     = 0;
        end else if (w.user && !(m_wx == 0 && m_wy == 0)) begin
            exp_q.delete();
            m_wx       = 0;
            m_wy       = 0;
            stall_prev = 1'b0;
            sof_next   = 1'b1;
        end
        if (w.npx > 0) exp_q.push_back(w.e0);
        if (w.npx > 1) exp_q.push_back(w.e1);
        m_wx++;
        if (m_wx == WPL) begin
            m_wx = 0;
            m_wy = (m_wy + 1) % YS;
        end
    endtask

    task automatic step(input bit want_valid, input bit rdy);
        bit          acc, emt;
        logic [26:0] now;
        @(negedge aclk);
        in_stream.tvalid = want_valid && (txq.size() > 0);
        if (txq.size() > 0) begin
            in_stream.tdata = txq[0].data;
            in_stream.tuser = txq[0].user;
            in_stream.tlast = txq[0].last;
        end
        out_ready = rdy;
        #1;
        now = {out_valid, r, g, b, out_sof, out_eol};
        if (stall_prev) check("hold", now, hold_val);
        check("valid", out_valid, (m_locked && exp_q.size() > 0));
        acc = in_stream.tvalid && in_stream.tready;
        emt = out_valid && out_ready;
        if (emt && exp_q.size() > 0) begin
            if (!first_seen) begin
                first_seen = 1'b1;
                first_px   = now[25:0];
            end
            if (sof_next) begin
                check("resync_sof", out_sof, 1'b1);
                sof_next = 1'b0;
            end
            check("pixel", now[25:0], exp_q.pop_front());
        end
        stall_prev = out_valid && !out_ready;
        hold_val   = now;
        if (acc) model_accept(txq.pop_front());
    endtask

    task automatic run(input int vpct, input int rpct, output int cycles);
        cycles = 0;
        while ((txq.size() > 0 || exp_q.size() > 0) && cycles < 5000) begin
            step($urandom_range(0, 99) < vpct, $urandom_range(0, 99) < rpct);
            cycles++;
        end
        check("drain", txq.size() + exp_q.size(), 0);
        @(negedge aclk);
        in_stream.tvalid = 1'b0;
        out_ready        = 1'b0;
        stall_prev       = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn          = 1'b0;
        in_stream.tvalid = 1'b1;
        in_stream.tuser  = 1'b1;
        out_ready        = 1'b1;
        repeat (3) @(negedge aclk);
        #1;
        check("rst_tready", in_stream.tready, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_locked", locked, 1'b0);
        check("rst_rgb", {r, g, b}, 24'h0);
        check("rst_flags", {out_sof, out_eol}, 2'b00);
        check("rst_errs", {sof_err_cnt, eol_err_cnt}, 0);
        txq.delete();
        exp_q.delete();
        m_locked   = 1'b0;
        m_wx       = 0;
        m_wy       = 0;
        stall_prev = 1'b0;
        sof_next   = 1'b0;
        aresetn          = 1'b1;
        in_stream.tvalid = 1'b0;
        in_stream.tuser  = 1'b0;
        out_ready        = 1'b0;
        #1;
        check("rel_tready", in_stream.tready, 1'b1);
        check("rel_locked", locked, 1'b0);
    endtask

    task automatic check_errs(input string tag, input int sof_e, input int eol_e);
        check({tag, "_sof_err"}, sof_err_cnt, ERR_EN ? sof_e : 0);
        check({tag, "_eol_err"}, eol_err_cnt, ERR_EN ? eol_e : 0);
    endtask

    initial begin
        int    cyc;
        word_t junk;
        aresetn          = 1'b0;
        in_stream.tvalid = 1'b0;
        in_stream.tdata  = '0;
        in_stream.tkeep  = '1;
        in_stream.tuser  = 1'b0;
        in_stream.tlast  = 1'b0;
        out_ready        = 1'b0;
        first_seen       = 1'b0;
        do_reset();

        // Words before the first tuser are discarded.
        for (int i = 0; i < 5; i++) begin
            junk.data = $urandom();
            junk.user = 1'b0;
            junk.last = 1'(i & 1);
            junk.npx  = 0;
            junk.e0   = '0;
            junk.e1   = '0;
            txq.push_back(junk);
        end
        run(100, 100, cyc);
        check("hunt_locked", locked, 1'b0);

        add_frame(FW, -1, -1, 1'b1);
        run(100, 100, cyc);
        check("first_px", first_px, {24'h332211, 1'b1, 1'b0});
        check("locked", locked, 1'b1);
        check("frame_cycles", cyc, XS * YS + 1);
        check_errs("clean", 0, 0);

        add_frame(FW, -1, -1, 1'b0);
        add_frame(FW, -1, -1, 1'b0);
        run(70, 50, cyc);
        check_errs("bp", 0, 0);

        // Early SOF: frame cut at word 6 of line 2, next frame starts there.
        add_frame(2 * WPL + 6, -1, -1, 1'b0);
        add_frame(FW, -1, -1, 1'b0);
        run(80, 60, cyc);
        check_errs("early_sof", 1, 0);

        add_frame(FW, 5, 2 * WPL - 1, 1'b0);
        run(85, 70, cyc);
        check_errs("eol", 1, 2);

        // Two more EOL errors push the 2-bit counter past all-ones.
        add_frame(FW, 7, WPL - 1, 1'b0);
        run(85, 70, cyc);
        check_errs("eol_sat", 1, 3);

        add_frame(FW, -1, -1, 1'b0);
        repeat (30) step(1'b1, 1'b1);
        do_reset();
        add_frame(FW, -1, -1, 1'b0);
        run(75, 75, cyc);
        check("relock", locked, 1'b1);
        check_errs("post_rst", 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
